// File: rtl/router_fifo.sv
// Router output-port FIFO: stores {header_flag, byte} words, tracks packet length
// on the read side and tri-states data_out at each packet boundary.
module router_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-3:0] count;
  logic             pkt_done;
  logic             hiz;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH:0]   rd_word;
  logic             do_write;
  logic             do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_write = write_enb && !full;
  assign do_read  = read_enb && !empty;
  assign rd_word  = mem[rd_ptr[AW-1:0]];
  assign data_out = hiz ? 'z : data_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!soft_reset && do_write) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // pkt_done remembers that the last read emptied the packet counter; the
  // boundary (Z) is shown on the next edge that does not accept a read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_done <= 1'b0;
      hiz      <= 1'b0;
      data_q   <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_done <= 1'b0;
      hiz      <= 1'b1;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= rd_word[WIDTH-1:0];
        hiz    <= 1'b0;
        if (rd_word[WIDTH]) begin
          count    <= rd_word[WIDTH-1:2] + 1'b1;
          pkt_done <= 1'b0;
        end else if (count != '0) begin
          count    <= count - 1'b1;
          pkt_done <= (count == (WIDTH-2)'(1));
        end else begin
          pkt_done <= 1'b0;
        end
      end else if (pkt_done) begin
        hiz      <= 1'b1;
        pkt_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, random traffic.
module tb_router_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             soft_reset = 1'b0;
  logic             write_enb = 1'b0;
  logic             read_enb = 1'b0;
  logic             lfd_state = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  tri1  [WIDTH-1:0] data_bus;   // released (Z) output reads as all-ones
  logic             full;
  logic             empty;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 1'b0;

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .read_enb  (read_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .data_out  (data_bus),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Reference model: occupancy queue plus packet bookkeeping.
  logic [WIDTH:0]   q[$];
  int               m_cnt = 0;
  bit               m_done = 1'b0;
  bit               m_hiz = 1'b0;
  logic [WIDTH-1:0] m_out = '0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_cnt = 0; m_done = 1'b0; m_hiz = 1'b0; m_out = '0;
    end else if (soft_reset) begin
      q.delete();
      m_cnt = 0; m_done = 1'b0; m_hiz = 1'b1;
    end else begin
      bit rd, wr;
      logic [WIDTH:0] w;
      rd = read_enb && (q.size() != 0);
      wr = write_enb && (q.size() != DEPTH);
      if (rd) begin
        w = q.pop_front();
        m_out = w[WIDTH-1:0];
        m_hiz = 1'b0;
        if (w[WIDTH]) begin
          m_cnt = (int'(w[WIDTH-1:2]) + 1) % 64;
          m_done = 1'b0;
        end else if (m_cnt > 0) begin
          m_cnt--;
          m_done = (m_cnt == 0);
        end else begin
          m_done = 1'b0;
        end
      end else if (m_done) begin
        m_hiz = 1'b1;
        m_done = 1'b0;
      end
      if (wr) q.push_back({lfd_state, data_in});
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("data_out", data_bus, m_hiz ? 8'hFF : m_out);
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
    end
  end

  task automatic cyc(input bit w, input bit r, input bit l, input logic [WIDTH-1:0] d);
    write_enb = w; read_enb = r; lfd_state = l; data_in = d;
    @(posedge clock); @(negedge clock); #2;
  endtask

  initial begin
    logic [WIDTH-1:0] pkt [5];
    logic [WIDTH-1:0] prev, d;
    pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h55;

    #13;
    chk("reset_data", data_bus, 8'h00);
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);
    @(negedge clock); #2;
    resetn = 1'b1;
    chk_en = 1'b1;

    // Header then payload, read back, then boundary Z
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk("pkt_word", data_bus, pkt[i]);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("pkt_boundary_z", data_bus, 8'hFF);
    chk("pkt_empty", empty, 1'b1);

    // Full, dropped 17th write, ordered drain
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    chk("full_after16", full, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("full_after17", full, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      chk("full_drain", data_bus, 8'(8'h10 + i));
    end
    chk("drained_empty", empty, 1'b1);

    // Simultaneous read+write at full and at empty
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'h99);
    chk("full_rw_data", data_bus, 8'h30);
    chk("full_rw_full", full, 1'b0);
    for (int i = 1; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("full_rw_last", data_bus, 8'h3F);
    chk("full_rw_empty", empty, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    chk("empty_rw_hold", data_bus, 8'h3F);
    chk("empty_rw_empty", empty, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("empty_rw_read", data_bus, 8'h77);

    // Soft reset flush
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h50 + i));
    soft_reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'h66);
    soft_reset = 1'b0;
    chk("soft_empty", empty, 1'b1);
    chk("soft_z", data_bus, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0, 8'h42);
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("soft_new_word", data_bus, 8'h42);

    // 40 streaming write/read pairs across pointer wrap
    cyc(1'b1, 1'b0, 1'b0, 8'h80);
    prev = 8'h80;
    for (int i = 0; i < 40; i++) begin
      d = 8'(8'h81 + i);
      cyc(1'b1, 1'b1, 1'b0, d);
      chk("wrap_order", data_bus, prev);
      chk("wrap_not_full", full, 1'b0);
      prev = d;
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("wrap_last", data_bus, prev);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      d = 8'($urandom);
      if (d == 8'hFF) d = 8'hFE;
      soft_reset = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom_range(0, 7) == 0, d);
      soft_reset = 1'b0;
    end

    // Asynchronous reset mid-clock with data stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cyc(1'b0, 1'b1, 1'b0, '0);
    #1 resetn = 1'b0;
    #1;
    chk("async_data", data_bus, 8'h00);
    chk("async_empty", empty, 1'b1);
    chk("async_full", full, 1'b0);
    @(negedge clock); #2;
    resetn = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, '0);
    chk("post_reset_empty", empty, 1'b1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage words (power of two).
REQ-002 SHALL have parameter WIDTH, default 8, payload byte width; stored word is WIDTH+1 bits (bit WIDTH = header flag).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port soft_reset  input  1  synchronous flush from router_sync, active high.
REQ-006 SHALL have port write_enb  input  1  one bit of router_sync write_enb; write request.
REQ-007 SHALL have port read_enb  input  1  read request from the output port.
REQ-008 SHALL have port lfd_state  input  1  high when data_in is the header byte.
REQ-009 SHALL have port data_in  input  WIDTH  byte to store.
REQ-010 SHALL have port data_out  output  WIDTH  registered read data.
REQ-011 SHALL have port full  output  1  combinational; high when DEPTH words are stored.
REQ-012 SHALL have port empty  output  1  combinational; high when 0 words are stored.

Function
REQ-013 SHALL keep write and read pointers of log2(DEPTH)+1 bits; the low bits address memory; the MSB is the wrap bit.
REQ-014 SHALL assert empty when the pointers are equal, including the wrap bit.
REQ-015 SHALL assert full when the address bits are equal and the wrap bits differ.
REQ-016 SHALL write {lfd_state, data_in} to mem[wr_ptr] and increment wr_ptr on an edge with write_enb=1 and full=0.
REQ-017 SHALL ignore a write when full=1; memory and wr_ptr stay unchanged.
REQ-018 SHALL, on an edge with read_enb=1 and empty=0, load data_out from mem[rd_ptr] and increment rd_ptr (1-cycle read latency).
REQ-019 SHALL ignore a read when empty=1; data_out and rd_ptr hold.
REQ-020 SHALL, on a simultaneous read and write when neither full nor empty, perform both; the occupancy is unchanged.
REQ-021 SHALL evaluate full and empty before the edge: full+read+write gives a read only; empty+read+write gives a write only.
REQ-022 SHALL wrap pointers modulo 2*DEPTH with no gap in data ordering.
REQ-023 SHALL keep a packet counter of WIDTH-2 bits (6 bits when WIDTH=8).
REQ-024 SHALL, when a word with header flag=1 is read, load the counter with data[WIDTH-1:2] + 1 (payload length + parity).
REQ-025 SHALL decrement the counter on each accepted read of a non-header word while the counter is nonzero.
REQ-026 SHALL drive data_out to all-Z on the edge after the counter reaches 0 through a read, with no read accepted on that edge; this marks the packet boundary.
REQ-027 SHALL restore data_out from Z to driven data on the next accepted read.
REQ-028 SHALL give priority resetn > soft_reset > read/write.

Reset
REQ-029 SHALL, while resetn=0 (asynchronous), clear both pointers, the counter, all memory words and data_out to 0; empty=1, full=0.
REQ-030 SHALL, on an edge with soft_reset=1, clear both pointers and the counter and set data_out to all-Z; memory contents are don't-care; reads and writes on that edge are discarded.
REQ-031 SHALL, when resetn is asserted mid-packet, abandon the packet; after release the FIFO is empty and the counter is 0.

Verification
REQ-032 SHALL cover reset: drive resetn=0 mid-clock -> data_out=0, empty=1, full=0 immediately without waiting for an edge.
REQ-033 SHALL cover a header-then-payload sequence: write header 8'h0D with lfd_state=1 (len 3) and payload 8'hA1/A2/A3, plus parity 8'h55 -> reading 5 words returns 0D,A1,A2,A3,55 one cycle after each read_enb, then data_out=Z.
REQ-034 SHALL cover full: write 16 words with no reads -> full=1 after the 16th edge; a 17th write is dropped and reads return words 1..16 in order.
REQ-035 SHALL cover the simultaneous boundary: when full, assert read and write together -> one word out, full drops to 0, new data not stored; when empty, assert both -> word stored, data_out unchanged, empty=0.
REQ-036 SHALL cover soft reset: load 5 words, then pulse soft_reset for one cycle -> empty=1 and data_out=Z on the next edge; a subsequent write/read returns the new word.
REQ-037 SHALL cover wrap-around: run 40 continuous single-word write/read pairs -> data order is preserved across pointer wrap, and full is never asserted.
